step_clock_generator: RTL and testbench



---
 rtl/step_clock_generator.sv | 129 ++++++++++++
 tb/tb_step_clock_generator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/step_clock_generator.sv
// Clock-enable source for the LED ripple counters: free-running divided tick or one tick per step
// press. Define STEP_CLOCK_GENERATOR_DEBOUNCE_EN to add the step-button debounce filter.
module step_clock_generator #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DB_CYCLES = 1000,
    parameter int unsigned DB_W      = 10
) (
    input  logic             input_clock1_1,
    input  logic             input_reset1_2,
    input  logic             input_run_3,
    input  logic             input_step_4,
    input  logic [DIV_W-1:0] input_div_5,
    output logic             output_tick_6,
    output logic             output_phase_7,
    output logic [1:0]       output_mode_8
);

    typedef enum logic [1:0] {
        StStep = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             phase_q;
    logic             s1_q, s2_q;
    logic             db;

    if (DB_CYCLES < 2 || DB_W < $clog2(DB_CYCLES)) begin : g_bad_db_params
        $error("step_clock_generator: DB_CYCLES must be >= 2 and fit in DB_W bits");
    end

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= input_step_4;
            s2_q <= s1_q;
        end
    end

`ifdef STEP_CLOCK_GENERATOR_DEBOUNCE_EN
    logic [DB_W-1:0] db_cnt_q;
    logic            db_q;

    // db follows s2 only after DB_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            db_cnt_q <= '0;
            db_q     <= 1'b0;
        end else if (s2_q == db_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
            db_cnt_q <= '0;
            db_q     <= s2_q;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    assign db = db_q;
`else
    assign db = s2_q;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        case (state_q)
            StStep: begin
                if (input_run_3) begin
                    state_d = StRun;
                    presc_d = '0;
                end else if (db) begin
                    tick_d  = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (input_run_3) begin
                    state_d = StRun;
                    presc_d = '0;
                end else if (!db) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                // Leaving RUN parks in HOLD so a button held across the switch cannot fire.
                if (!input_run_3) begin
                    state_d = StHold;
                end else if (presc_q >= input_div_5) begin
                    tick_d  = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                state_d = StStep;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            state_q <= StStep;
            presc_q <= '0;
            tick_q  <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            if (tick_d) begin
                phase_q <= ~phase_q;
            end
        end
    end

    assign output_tick_6  = tick_q;
    assign output_phase_7 = phase_q;
    assign output_mode_8  = state_q;

endmodule

// File: tb/tb_step_clock_generator.sv
// Scoreboard bench for step_clock_generator: expected ticks are queued by the stimulus and
// matched by an independent monitor against edge number, phase and mode.
module tb_step_clock_generator;

    localparam int DBC = 4;
`ifdef STEP_CLOCK_GENERATOR_DEBOUNCE_EN
    localparam int DBL = DBC;
`else
    localparam int DBL = 0;
`endif
    localparam int MStep = 0;
    localparam int MRun  = 1;
    localparam int MHold = 2;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        run  = 1'b0;
    logic        step = 1'b0;
    logic [15:0] div  = '0;
    logic        tick;
    logic        phase;
    logic [1:0]  mode;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int   edge_n;
        logic phase;
        int   mode;
    } exp_t;

    exp_t sb[$];
    logic exp_phase = 1'b0;

    step_clock_generator #(
        .DIV_W     (16),
        .DB_CYCLES (DBC),
        .DB_W      (3)
    ) dut (
        .input_clock1_1 (clk),
        .input_reset1_2 (rst),
        .input_run_3    (run),
        .input_step_4   (step),
        .input_div_5    (div),
        .output_tick_6  (tick),
        .output_phase_7 (phase),
        .output_mode_8  (mode)
    );

    always #5 clk = ~clk;

    // cyc == N at the negedge following posedge N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_tick(input int e, input int m);
        exp_t x;
        exp_phase = ~exp_phase;
        x.edge_n  = e;
        x.phase   = exp_phase;
        x.mode    = m;
        sb.push_back(x);
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (tick === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_tick: tick=1 at edge %0d, expected 0", cyc);
            end else begin
                x = sb.pop_front();
                check("tick_edge", cyc, x.edge_n);
                check("tick_phase", int'(phase), int'(x.phase));
                check("tick_mode", int'(mode), x.mode);
            end
        end
    end

    initial begin
        int t;
        int e1;
        int r;

        repeat (3) @(negedge clk);
        check("rst_tick", int'(tick), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_mode", int'(mode), MStep);
        rst = 1'b0;

        // Free run, div=3: ticks 4, 8, 12 edges after entering RUN.
        @(negedge clk);
        run = 1'b1;
        div = 16'd3;
        t   = cyc + 1;
        expect_tick(t + 4, MRun);
        expect_tick(t + 8, MRun);
        expect_tick(t + 12, MRun);
        wait_edge(t + 12);
        check("run_mode", int'(mode), MRun);

        // div 9 -> 2 while prescaler is 5: immediate tick, then period 3.
        div = 16'd9;
        wait_edge(t + 17);
        div = 16'd2;
        expect_tick(t + 18, MRun);
        expect_tick(t + 21, MRun);
        expect_tick(t + 24, MRun);
        wait_edge(t + 24);
        run = 1'b0;
        wait_edge(t + 25);
        check("runoff_hold", int'(mode), MHold);
        wait_edge(t + 26);
        check("runoff_step", int'(mode), MStep);

        // Stable 10-cycle press: exactly one tick.
        @(negedge clk);
        step = 1'b1;
        e1   = cyc + 1;
        expect_tick(e1 + 2 + DBL, MHold);
        wait_edge(e1 + 9);
        step = 1'b0;
        r    = cyc + 1;
        wait_edge(r + 1 + DBL);
        check("release_hold", int'(mode), MHold);
        wait_edge(r + 2 + DBL);
        check("release_step", int'(mode), MStep);

        // 3-cycle glitch: filtered with debounce, a full press without.
        @(negedge clk);
        step = 1'b1;
        e1   = cyc + 1;
        if (DBL == 0) expect_tick(e1 + 2, MHold);
        wait_edge(e1 + 2);
        step = 1'b0;
        wait_edge(e1 + 3);
        check("glitch_mode", int'(mode), (DBL == 0) ? MHold : MStep);
        wait_edge(e1 + 12);
        check("glitch_after", int'(mode), MStep);

        // Button held across RUN -> step: lands in HOLD, no tick until a new press.
        step = 1'b1;
        run  = 1'b1;
        div  = 16'd100;
        t    = cyc + 1;
        wait_edge(t + 9);
        check("held_run_mode", int'(mode), MRun);
        run = 1'b0;
        wait_edge(t + 15);
        check("held_hold_mode", int'(mode), MHold);
        step = 1'b0;
        r    = cyc + 1;
        wait_edge(r + 2 + DBL);
        check("held_rel_step", int'(mode), MStep);
        step = 1'b1;
        e1   = cyc + 1;
        expect_tick(e1 + 2 + DBL, MHold);
        wait_edge(e1 + 3 + DBL);
        step = 1'b0;
        wait_edge(cyc + DBL + 4);
        check("repress_step", int'(mode), MStep);

        // div=0: tick every edge; reset mid-stream clears everything at that edge.
        run = 1'b1;
        div = 16'd0;
        t   = cyc + 1;
        for (int i = 1; i <= 5; i++) expect_tick(t + i, MRun);
        wait_edge(t + 5);
        rst = 1'b1;
        wait_edge(t + 6);
        exp_phase = 1'b0;
        check("midrst_tick", int'(tick), 0);
        check("midrst_phase", int'(phase), 0);
        check("midrst_mode", int'(mode), MStep);
        wait_edge(t + 10);
        check("inrst_mode", int'(mode), MStep);
        check("inrst_phase", int'(phase), 0);
        rst = 1'b0;
        run = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
